// File: rtl/contador_gray_pkg.sv
// Shared constants and gray/binary helpers for the gray counter sequencer.
package contador_gray_pkg;

    localparam int WIDTH_DEF = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_PAUSED = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // 32-bit forms: callers zero-extend narrower words and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_a_bin.sv
// Combinational WIDTH-bit gray-to-binary converter.
module gray_a_bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the parity of the gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/contador_gray_ctrl.sv
// Run sequencer for an external gray counter: clear, step N times, pause/stop, report.
// Optional gray-sequence checker enabled with macro GRAY_CHECK_EN.
module contador_gray_ctrl
    import contador_gray_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = WIDTH + 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              pause,
    input  logic              stop,
    input  logic [WIDTH-1:0]  gray_in,
    output logic              cnt_enable,
    output logic              cnt_reset_L,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              error,
    output logic [WIDTH-1:0]  result_gray,
    output logic [WIDTH-1:0]  result_bin
);

    logic [2:0]        state_q, state_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              ab_q, ab_d;
    logic              en_q, en_d;
    logic              rstl_q, rstl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  rg_q, rg_d;
    logic [WIDTH-1:0]  rb_q, rb_d;
    logic [WIDTH-1:0]  gin_bin;
    logic              step;
    logic              mis;

    gray_a_bin #(.WIDTH(WIDTH)) u_gray_a_bin (
        .gray (gray_in),
        .bin  (gin_bin)
    );

    // A step is one counter increment; a paused cycle that sees pause drop resumes stepping at once.
    assign step = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) && !stop && !pause;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ab_d    = ab_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    rem_d   = num_steps;
                    ab_d    = 1'b0;
                end
            end
            ST_CLEAR: state_d = (rem_q != '0) ? ST_RUN : ST_SETTLE;
            ST_RUN, ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_SETTLE;
                    ab_d    = 1'b1;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else begin
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == STEP_W'(1)) ? ST_SETTLE : ST_RUN;
                end
            end
            ST_SETTLE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             chk_win;

    // Tracks the counter value: bumps on the same edge the counter consumes an enable.
    always_comb begin
        exp_d = exp_q;
        if (state_q == ST_CLEAR) exp_d = '0;
        else if (en_q)           exp_d = exp_q + 1'b1;
    end

    // Skip the cycle the counter is held in reset; its output is not yet defined.
    assign chk_win = ((state_q == ST_RUN) || (state_q == ST_PAUSED) ||
                      (state_q == ST_SETTLE)) && rstl_q;
    assign mis     = chk_win && (gin_bin != exp_q);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) exp_q <= '0;
        else          exp_q <= exp_d;
    end
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        en_d      = step;
        rstl_d    = (state_q != ST_CLEAR);
        busy_d    = (state_q != ST_IDLE);
        done_d    = (state_q == ST_DONE);
        aborted_d = (state_q == ST_DONE) && ab_q;
        rg_d      = rg_q;
        rb_d      = rb_q;
        if (state_q == ST_DONE) begin
            rg_d = gray_in;
            rb_d = gin_bin;
        end
        err_d = err_q;
        if ((state_q == ST_IDLE) && start) err_d = 1'b0;
        else if (mis)                      err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            ab_q      <= 1'b0;
            en_q      <= 1'b0;
            rstl_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            rg_q      <= '0;
            rb_q      <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            ab_q      <= ab_d;
            en_q      <= en_d;
            rstl_q    <= rstl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
            rg_q      <= rg_d;
            rb_q      <= rb_d;
        end
    end

    assign cnt_enable  = en_q;
    assign cnt_reset_L = rstl_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign error       = err_q;
    assign result_gray = rg_q;
    assign result_bin  = rb_q;

endmodule

// File: tb/tb_contador_gray_ctrl.sv
// Self-checking bench for contador_gray_ctrl with a stub gray counter attached.
module tb_contador_gray_ctrl;

    localparam int W  = 5;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic [W-1:0]  gray_in;
    logic          cnt_enable, cnt_reset_L, busy, done, aborted, error;
    logic [W-1:0]  result_gray, result_bin;

    logic [W-1:0]  cnt;
    logic          flip = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    contador_gray_ctrl dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .start       (start),
        .num_steps   (num_steps),
        .pause       (pause),
        .stop        (stop),
        .gray_in     (gray_in),
        .cnt_enable  (cnt_enable),
        .cnt_reset_L (cnt_reset_L),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .error       (error),
        .result_gray (result_gray),
        .result_bin  (result_bin)
    );

    // Stand-in for the external counter; flip injects a one-cycle corrupted bit 2.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)          cnt <= '0;
        else if (!cnt_reset_L) cnt <= '0;
        else if (cnt_enable)   cnt <= cnt + 1'b1;
    end
    assign gray_in = (cnt ^ (cnt >> 1)) ^ (flip ? 5'b00100 : 5'b00000);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"},   32'(cnt_enable), 0);
        chk({tag, "_rstl"}, 32'(cnt_reset_L), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ab"},   32'(aborted), 0);
        chk({tag, "_err"},  32'(error), 0);
        chk({tag, "_rg"},   32'(result_gray), 0);
        chk({tag, "_rb"},   32'(result_bin), 0);
    endtask

    // k steps; pause high in cycles [ps, ps+pl); stop in cycle sa; flip in cycle fl;
    // extra start in cycle rs. Cycle c is the one following the c-th edge after start.
    task automatic run(input string tag, input int k, input int ps, input int pl,
                       input int sa, input int fl, input int rs, input bit wrap_exp);
        int steps = 0, jend = 0, en = 0, dcyc = -1;
        bit ab = 0, wrap = 0, err_exp;
        logic [W-1:0] pg, rg = '0, rb = '0, eb;
        logic ra = 1'b0, re = 1'b0;
        if (k != 0) begin
            for (int j = 1; j < 200; j++) begin
                if (j == sa) begin ab = 1; jend = j; break; end
                if (!(j >= ps && j < ps + pl)) begin
                    steps++;
                    if (steps == k) begin jend = j; break; end
                end
            end
        end
`ifdef GRAY_CHECK_EN
        err_exp = (fl >= 2) && (fl <= jend + 1);
`else
        err_exp = 0;
`endif
        @(negedge clk);
        start = 1'b1;
        num_steps = SW'(k);
        pg = gray_in;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) chk({tag, "_err_clr"}, 32'(error), 0);
            en += int'(cnt_enable);
            if (pg == 5'b10000 && gray_in == 5'b00000) wrap = 1;
            pg = gray_in;
            if (done) begin
                dcyc = c; rg = result_gray; rb = result_bin; ra = aborted; re = error;
            end
            if (dcyc >= 0 && c == dcyc + 1) begin
                chk({tag, "_busy_after"}, 32'(busy), 0);
                break;
            end
            start = (c == rs);
            num_steps = SW'($urandom);
            pause = (c >= ps) && (c < ps + pl);
            stop = (c == sa);
            flip = (c == fl);
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0; flip = 1'b0;
        eb = W'(steps % 32);
        chk({tag, "_latency"}, 32'(dcyc), 32'(jend + 3));
        chk({tag, "_enables"}, 32'(en), 32'(steps));
        chk({tag, "_rgray"}, 32'(rg), 32'(eb ^ (eb >> 1)));
        chk({tag, "_rbin"}, 32'(rb), 32'(eb));
        chk({tag, "_aborted"}, 32'(ra), 32'(ab));
        chk({tag, "_error"}, 32'(re), 32'(err_exp));
        if (wrap_exp) chk({tag, "_wrap"}, 32'(wrap), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        reset_L = 1'b1;
        @(negedge clk);

        run("k5",        5, 0, 0, -1, -1, -1, 0);
        run("k0",        0, 0, 0, -1, -1, -1, 0);
        run("k10_pause", 10, 4, 4, -1, -1, -1, 0);
        run("k20_stop",  20, 0, 0, 8, -1, -1, 0);
        run("k32_wrap",  32, 0, 0, -1, -1, 5, 1);
        run("stop_last", 4, 0, 0, 4, -1, -1, 0);
        run("stop_pau",  15, 3, 6, 5, -1, 2, 0);
        run("flip",      12, 0, 0, -1, 6, -1, 0);
        run("after_flip", 3, 0, 0, -1, -1, -1, 0);

        for (int i = 0; i < 8; i++) begin
            int k, ps, pl, sa, rs;
            k  = int'($urandom_range(0, 32));
            ps = int'($urandom_range(1, 20));
            pl = int'($urandom_range(0, 5));
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : -1;
            rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : -1;
            run($sformatf("rnd%0d", i), k, ps, pl, sa, -1, rs, 0);
        end

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        num_steps = SW'(20);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        reset_L = 1'b0;
        #1;
        chk_reset("midrst");
        chk("midrst_gray", 32'(gray_in), 0);
        @(negedge clk);
        reset_L = 1'b1;
        run("post_rst", 6, 0, 0, -1, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
